logic_op_arbiter: RTL and testbench

Shared-resource controller for the 32-bit logic unit (AND/OR/NOR/INV). Two requesters submit logic operations over valid/ready handshakes. The block arbitrates round-robin, captures the winner's operands, executes them on a single logic datapath, and returns the registered result on the winner's response channel. It sits between the instruction-execute logic and the shared 32-bit logic gate arrays, so both clients use one copy of the gate hardware.

---
 rtl/logic_op_arbiter_pkg.sv | 22 ++
 rtl/logic_op_arbiter_if.sv | 29 ++
 rtl/logic_op_arbiter_logic32_unit.sv | 37 +++
 rtl/logic_op_arbiter.sv | 116 +++++++++++
 tb/tb_logic_op_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/logic_op_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | logic_op_arbiter_pkg : shared opcodes, FSM states and data width      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package logic_op_arbiter_pkg;

   localparam int DATA_WIDTH = 32;

   localparam logic [1:0] LOGIC_OP_AND = 2'b00;
   localparam logic [1:0] LOGIC_OP_OR  = 2'b01;
   localparam logic [1:0] LOGIC_OP_NOR = 2'b10;
   localparam logic [1:0] LOGIC_OP_INV = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage : logic_op_arbiter_pkg
`default_nettype wire

// File: rtl/logic_op_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | logic_op_arbiter_if : one client's request/response channel pair      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface logic_op_arbiter_if;
   import logic_op_arbiter_pkg::*;

   logic                  req_valid;
   logic                  req_ready;
   logic [1:0]            req_op;
   logic [DATA_WIDTH-1:0] req_a;
   logic [DATA_WIDTH-1:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_data;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );

endinterface : logic_op_arbiter_if
`default_nettype wire

// File: rtl/logic_op_arbiter_logic32_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | logic32_unit : combinational AND/OR/NOR/INV arrays with 4:1 select    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module logic32_unit
   import logic_op_arbiter_pkg::*;
(
   input  wire logic [1:0]            op,
   input  wire logic [DATA_WIDTH-1:0] a,
   input  wire logic [DATA_WIDTH-1:0] b,
   output logic      [DATA_WIDTH-1:0] y
);

   logic [DATA_WIDTH-1:0] and_w;
   logic [DATA_WIDTH-1:0] or_w;
   logic [DATA_WIDTH-1:0] nor_w;
   logic [DATA_WIDTH-1:0] inv_w;

   assign and_w = a & b;
   assign or_w  = a | b;
   assign nor_w = ~(a | b);
   assign inv_w = ~a;

   always_comb begin
      y = and_w;
      case (op)
         LOGIC_OP_AND: y = and_w;
         LOGIC_OP_OR:  y = or_w;
         LOGIC_OP_NOR: y = nor_w;
         LOGIC_OP_INV: y = inv_w;
         default:      y = and_w;
      endcase
   end

endmodule : logic32_unit
`default_nettype wire

// File: rtl/logic_op_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | logic_op_arbiter : round-robin two-client front end for logic32_unit  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module logic_op_arbiter
   import logic_op_arbiter_pkg::*;
(
   input  wire logic          clk,
   input  wire logic          rst,
   logic_op_arbiter_if.slave  req0,
   logic_op_arbiter_if.slave  req1,
   output logic               busy
);

   state_t                state_q, state_d;
   logic                  pri_q, pri_d;
   logic                  g_q, g_d;
   logic [1:0]            op_q, op_d;
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  busy_q, busy_d;
   logic                  rsp0_valid_q, rsp0_valid_d;
   logic                  rsp1_valid_q, rsp1_valid_d;

   logic                  grant_w;
   logic                  any_valid_w;
   logic                  rsp_ready_w;
   logic [DATA_WIDTH-1:0] unit_y_w;

   logic32_unit u_logic32_unit (
      .op (op_q),
      .a  (a_q),
      .b  (b_q),
      .y  (unit_y_w)
   );

   // PRI only decides ties; a lone requester always wins.
   assign grant_w     = (req0.req_valid & req1.req_valid) ? pri_q : req1.req_valid;
   assign any_valid_w = req0.req_valid | req1.req_valid;
   assign rsp_ready_w = g_q ? req1.rsp_ready : req0.rsp_ready;

   assign req0.req_ready = (state_q == ST_IDLE) & ~rst & req0.req_valid & ~grant_w;
   assign req1.req_ready = (state_q == ST_IDLE) & ~rst & req1.req_valid &  grant_w;

   always_comb begin
      state_d  = state_q;
      pri_d    = pri_q;
      g_d      = g_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (any_valid_w) begin
               g_d     = grant_w;
               op_d    = grant_w ? req1.req_op : req0.req_op;
               a_d     = grant_w ? req1.req_a  : req0.req_a;
               b_d     = grant_w ? req1.req_b  : req0.req_b;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            result_d = unit_y_w;
            state_d  = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready_w) begin
               pri_d   = ~g_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Outputs are registered from the next state so they line up with state_q.
      busy_d       = (state_d != ST_IDLE);
      rsp0_valid_d = (state_d == ST_RESP) & ~g_d;
      rsp1_valid_d = (state_d == ST_RESP) &  g_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         pri_q        <= 1'b0;
         g_q          <= 1'b0;
         op_q         <= 2'b00;
         a_q          <= '0;
         b_q          <= '0;
         result_q     <= '0;
         busy_q       <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pri_q        <= pri_d;
         g_q          <= g_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         result_q     <= result_d;
         busy_q       <= busy_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
      end
   end

   assign req0.rsp_valid = rsp0_valid_q;
   assign req1.rsp_valid = rsp1_valid_q;
   assign req0.rsp_data  = result_q;
   assign req1.rsp_data  = result_q;
   assign busy           = busy_q;

endmodule : logic_op_arbiter
`default_nettype wire

// File: tb/tb_logic_op_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_logic_op_arbiter : directed self-checking bench for the arbiter    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_logic_op_arbiter;

   logic clk;
   logic rst;
   logic busy;
   int   n_checks;
   int   n_pass;

   logic_op_arbiter_if req0_if ();
   logic_op_arbiter_if req1_if ();

   logic_op_arbiter u_dut (
      .clk  (clk),
      .rst  (rst),
      .req0 (req0_if),
      .req1 (req1_if),
      .busy (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req0(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      req0_if.req_valid = v;
      req0_if.req_op    = op;
      req0_if.req_a     = a;
      req0_if.req_b     = b;
   endtask

   task automatic set_req1(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      req1_if.req_valid = v;
      req1_if.req_op    = op;
      req1_if.req_a     = a;
      req1_if.req_b     = b;
   endtask

   // One full operation with immediate response ready: accept, EXEC, RESP, IDLE.
   task automatic serve_one(input string tag, input logic g, input logic [31:0] exp_data);
      req0_if.rsp_ready = 1'b1;
      req1_if.rsp_ready = 1'b1;
      #1;
      check({tag, "_rdy0"}, {31'd0, req0_if.req_ready}, {31'd0, ~g});
      check({tag, "_rdy1"}, {31'd0, req1_if.req_ready}, {31'd0, g});
      tick();
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      tick();
      check({tag, "_vld0"}, {31'd0, req0_if.rsp_valid}, {31'd0, ~g});
      check({tag, "_vld1"}, {31'd0, req1_if.rsp_valid}, {31'd0, g});
      check({tag, "_data"}, g ? req1_if.rsp_data : req0_if.rsp_data, exp_data);
      tick();
      check({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      clk      = 1'b0;
      rst      = 1'b1;
      set_req0(1'b1, 2'b00, 32'hFFFF0000, 32'h0F0F0F0F);
      set_req1(1'b0, 2'b00, 32'h0, 32'h0);
      req0_if.rsp_ready = 1'b0;
      req1_if.rsp_ready = 1'b0;

      // Reset held two cycles with REQ0 pending
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_rdy0", {31'd0, req0_if.req_ready}, 32'd0);
         check("rst_vld0", {31'd0, req0_if.rsp_valid}, 32'd0);
         check("rst_vld1", {31'd0, req1_if.rsp_valid}, 32'd0);
         check("rst_busy", {31'd0, busy}, 32'd0);
         check("rst_data", req0_if.rsp_data, 32'h00000000);
      end
      rst = 1'b0;
      #1;
      check("post_rst_rdy0", {31'd0, req0_if.req_ready}, 32'd1);

      // Single AND with three cycles of backpressure
      tick();
      req0_if.req_valid = 1'b0;
      check("and_busy", {31'd0, busy}, 32'd1);
      check("and_no_early_vld", {31'd0, req0_if.rsp_valid}, 32'd0);
      tick();
      check("and_vld", {31'd0, req0_if.rsp_valid}, 32'd1);
      check("and_data", req0_if.rsp_data, 32'h0F0F0000);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_vld0", {31'd0, req0_if.rsp_valid}, 32'd1);
         check("bp_data", req0_if.rsp_data, 32'h0F0F0000);
         check("bp_vld1", {31'd0, req1_if.rsp_valid}, 32'd0);
      end
      req0_if.rsp_ready = 1'b1;
      tick();
      req0_if.rsp_ready = 1'b0;
      check("and_done_vld", {31'd0, req0_if.rsp_valid}, 32'd0);
      check("and_done_busy", {31'd0, busy}, 32'd0);

      // Simultaneous requests from reset, alternating grant
      rst = 1'b1;
      set_req0(1'b1, 2'b01, 32'h12340000, 32'h00005678);
      set_req1(1'b1, 2'b10, 32'h00000000, 32'h00000000);
      tick();
      rst = 1'b0;
      serve_one("sim0", 1'b0, 32'h12345678);
      serve_one("sim1", 1'b1, 32'hFFFFFFFF);
      serve_one("alt0", 1'b0, 32'h12345678);
      serve_one("alt1", 1'b1, 32'hFFFFFFFF);

      // INV ignores B
      req0_if.req_valid = 1'b0;
      set_req1(1'b1, 2'b11, 32'hA5A5A5A5, 32'hDEADBEEF);
      serve_one("inv", 1'b1, 32'h5A5A5A5A);

      // Leave PRI at 1, then reset during EXEC
      set_req1(1'b0, 2'b00, 32'h0, 32'h0);
      set_req0(1'b1, 2'b00, 32'hFFFF0000, 32'h0F0F0F0F);
      serve_one("pre_exec", 1'b0, 32'h0F0F0000);
      req0_if.req_valid = 1'b0;
      set_req1(1'b1, 2'b01, 32'h00000001, 32'h00000002);
      #1;
      check("rexec_rdy1", {31'd0, req1_if.req_ready}, 32'd1);
      tick();
      req1_if.req_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rexec_busy", {31'd0, busy}, 32'd0);
      check("rexec_vld1", {31'd0, req1_if.rsp_valid}, 32'd0);
      tick();
      check("rexec_vld1_late", {31'd0, req1_if.rsp_valid}, 32'd0);
      check("rexec_busy_late", {31'd0, busy}, 32'd0);
      set_req0(1'b1, 2'b01, 32'h12340000, 32'h00005678);
      set_req1(1'b1, 2'b10, 32'h00000000, 32'h00000000);
      serve_one("pri_rexec", 1'b0, 32'h12345678);

      // PRI is 1 again; reset during RESP
      req0_if.req_valid = 1'b0;
      req1_if.rsp_ready = 1'b0;
      #1;
      check("rresp_rdy1", {31'd0, req1_if.req_ready}, 32'd1);
      tick();
      req1_if.req_valid = 1'b0;
      tick();
      check("rresp_vld1", {31'd0, req1_if.rsp_valid}, 32'd1);
      check("rresp_data", req1_if.rsp_data, 32'hFFFFFFFF);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rresp_vld1_gone", {31'd0, req1_if.rsp_valid}, 32'd0);
      check("rresp_busy", {31'd0, busy}, 32'd0);
      check("rresp_data_clr", req1_if.rsp_data, 32'h00000000);
      tick();
      check("rresp_vld1_late", {31'd0, req1_if.rsp_valid}, 32'd0);
      req0_if.req_valid = 1'b1;
      req1_if.req_valid = 1'b1;
      serve_one("pri_rresp", 1'b0, 32'h12345678);

      // Operand isolation and no accept while occupied
      req1_if.req_valid = 1'b0;
      set_req0(1'b1, 2'b00, 32'hF0F0F0F0, 32'hFFFFFFFF);
      req0_if.rsp_ready = 1'b0;
      #1;
      check("iso_rdy0", {31'd0, req0_if.req_ready}, 32'd1);
      tick();
      set_req0(1'b0, 2'b00, 32'h00000000, 32'hFFFFFFFF);
      set_req1(1'b1, 2'b01, 32'h00000001, 32'h00000002);
      #1;
      check("iso_exec_rdy1", {31'd0, req1_if.req_ready}, 32'd0);
      tick();
      check("iso_vld0", {31'd0, req0_if.rsp_valid}, 32'd1);
      check("iso_data", req0_if.rsp_data, 32'hF0F0F0F0);
      check("iso_resp_rdy1", {31'd0, req1_if.req_ready}, 32'd0);
      tick();
      check("iso_bp_rdy1", {31'd0, req1_if.req_ready}, 32'd0);
      check("iso_bp_vld1", {31'd0, req1_if.rsp_valid}, 32'd0);
      req0_if.rsp_ready = 1'b1;
      tick();
      check("iso_done_busy", {31'd0, busy}, 32'd0);
      serve_one("iso_req1", 1'b1, 32'h00000003);
      req1_if.req_valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_logic_op_arbiter
`default_nettype wire
